// File: rtl/edge_task_dispatch_rs.sv
// Reservation station and dispatcher feeding the Edge PE array from the command decoder.
// Define EDGE_RS_RR_ARB_EN for round-robin PE selection; otherwise the lowest-index available PE wins.
module edge_task_dispatch_rs #(
  parameter int NUM_PE = 4,
  parameter int DEPTH  = 8,
  parameter int TASK_W = 32,
  parameter int ITER_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TASK_W-1:0]          in_task,
  input  logic [ITER_W-1:0]          in_iter,
  input  logic [ITER_W-1:0]          cur_iter,
  input  logic [NUM_PE-1:0]          pe_idle,
  output logic [NUM_PE-1:0]          out_valid,
  output logic [NUM_PE*TASK_W-1:0]   out_task,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = $clog2(NUM_PE);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TASK_W-1:0] task_q [DEPTH];
  logic [TASK_W-1:0] task_d [DEPTH];
  logic [ITER_W-1:0] iter_q [DEPTH];
  logic [ITER_W-1:0] iter_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [NUM_PE-1:0] out_valid_q, out_valid_d;
  logic [TASK_W-1:0] out_task_q [NUM_PE];
  logic [TASK_W-1:0] out_task_d [NUM_PE];
  logic [NUM_PE-1:0] resv_q, resv_d;

  logic [DEPTH:0]    valid_ext;
  logic [TASK_W-1:0] task_ext [DEPTH+1];
  logic [ITER_W-1:0] iter_ext [DEPTH+1];

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [NUM_PE-1:0] avail;
  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  logic [NUM_PE-1:0] grant_oh;
  logic              do_disp;
  logic              accept;
  logic [CNT_W-1:0]  ins_idx;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;
  assign accept   = in_valid && in_ready;
  assign avail    = pe_idle & ~resv_q;
  assign do_disp  = sel_found && grant_found;
  assign ins_idx  = count_q - CNT_W'(do_disp);
  assign out_valid = out_valid_q;

  for (genvar p = 0; p < NUM_PE; p++) begin : g_out_pack
    assign out_task[p*TASK_W +: TASK_W] = out_task_q[p];
  end

  // One spare empty slot past the top so the shift-down never reads out of range.
  always_comb begin
    valid_ext = {1'b0, valid_q};
    task_ext[DEPTH] = '0;
    iter_ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      task_ext[i] = task_q[i];
      iter_ext[i] = iter_q[i];
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (valid_q[i] && (iter_q[i] == cur_iter)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

`ifdef EDGE_RS_RR_ARB_EN
  localparam int PSUM_W = PTR_W + 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PSUM_W-1:0] cand_sum;
  logic [PTR_W-1:0]  cand;

  // Scan from rr_ptr upward with wraparound; the nearest available PE wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int k = NUM_PE-1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr_q} + PSUM_W'(k);
      if (cand_sum >= PSUM_W'(NUM_PE)) begin
        cand_sum = cand_sum - PSUM_W'(NUM_PE);
      end
      cand = cand_sum[PTR_W-1:0];
      if (avail[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (do_disp) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_PE-1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int p = NUM_PE-1; p >= 0; p--) begin
      if (avail[p]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(p);
      end
    end
  end
`endif

  always_comb begin
    grant_oh = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      grant_oh[p] = do_disp && (grant_idx == PTR_W'(p));
    end
  end

  // Remove the dispatched entry by shifting younger entries down, then append the new task.
  always_comb begin
    valid_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_ext[i];
      task_d[i]  = task_ext[i];
      iter_d[i]  = iter_ext[i];
      if (do_disp && (IDX_W'(i) >= sel_idx)) begin
        valid_d[i] = valid_ext[i+1];
        task_d[i]  = task_ext[i+1];
        iter_d[i]  = iter_ext[i+1];
      end
      if (accept && (CNT_W'(i) == ins_idx)) begin
        valid_d[i] = 1'b1;
        task_d[i]  = in_task;
        iter_d[i]  = in_iter;
      end
    end
    count_d = count_q + CNT_W'(accept) - CNT_W'(do_disp);
  end

  // resv mirrors the dispatch strobe: it masks the PE while its idle flag catches up.
  always_comb begin
    out_valid_d = grant_oh;
    resv_d      = grant_oh;
    for (int p = 0; p < NUM_PE; p++) begin
      out_task_d[p] = out_task_q[p];
      if (grant_oh[p]) begin
        out_task_d[p] = task_q[sel_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      count_q     <= '0;
      out_valid_q <= '0;
      resv_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        task_q[i] <= '0;
        iter_q[i] <= '0;
      end
      for (int p = 0; p < NUM_PE; p++) begin
        out_task_q[p] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      resv_q      <= resv_d;
      for (int i = 0; i < DEPTH; i++) begin
        task_q[i] <= task_d[i];
        iter_q[i] <= iter_d[i];
      end
      for (int p = 0; p < NUM_PE; p++) begin
        out_task_q[p] <= out_task_d[p];
      end
    end
  end

endmodule
